pixel_frame_sequencer: RTL



---
 rtl/pixel_pkg.sv | 22 ++
 rtl/pixel_ram.sv | 33 +++
 rtl/pixel_frame_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame sequencer and its pixel RAM.
package pixel_pkg;

    localparam int COLOR_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PRESENT = 3'd2,
        ST_RSTCMD  = 3'd3,
        ST_FINISH  = 3'd4
    } state_t;

    localparam logic CMD_COLOR = 1'b0;
    localparam logic CMD_RESET = 1'b1;

    // States in which a command is offered to pixel_driver
    function automatic logic is_cmd_state(input state_t s);
        return (s == ST_PRESENT) || (s == ST_RSTCMD);
    endfunction

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port colour RAM: one write port, one registered read port.
// A read that collides with a write to the same address returns the old word.
module pixel_ram
    import pixel_pkg::*;
#(
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [COLOR_W-1:0]   wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [COLOR_W-1:0]   rd_data
);

    logic [COLOR_W-1:0] mem_r [2**ADDR_BITS];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its word until the next enabled read
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Streams one frame of colours from the local pixel RAM to pixel_driver,
// adding a single reset-latch command before or after the colours.
module pixel_frame_sequencer
    import pixel_pkg::*;
#(
    parameter int NUM_PIXELS  = 64,
    parameter int ADDR_BITS   = 6,
    parameter int RESET_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [COLOR_W-1:0]   wr_color,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [COLOR_W-1:0]   pix_color,
    output logic                 pix_reset,
    output logic                 pix_valid,
    input  logic                 pix_ready
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_PIXELS - 1);
    localparam logic [ADDR_BITS-1:0] ONE_IDX  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ZERO_IDX = ADDR_BITS'(0);
    localparam logic                 RF       = (RESET_FIRST != 0);

    state_t               state_r, state_s;
    logic [ADDR_BITS-1:0] index_r, index_s;
    logic                 rd_en_s, xfer_s, valid_s;
    logic                 valid_r, rst_cmd_r, busy_r, done_r;
    logic [COLOR_W-1:0]   rd_data_s;

    pixel_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_color),
        .rd_en   (rd_en_s),
        .rd_addr (index_r),
        .rd_data (rd_data_s)
    );

    assign xfer_s = valid_r && pix_ready;

    // Next-state, index and RAM read control
    always_comb begin
        state_s = state_r;
        index_s = index_r;
        rd_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    index_s = ZERO_IDX;
                    state_s = RF ? ST_RSTCMD : ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rd_en_s = 1'b1;
                state_s = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (xfer_s) begin
                    if (index_r == LAST_IDX) begin
                        state_s = RF ? ST_FINISH : ST_RSTCMD;
                    end else begin
                        index_s = index_r + ONE_IDX;
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_PRESENT;
                end
            end
            ST_RSTCMD: begin
                if (xfer_s) begin
                    if (RF) begin
                        index_s = ZERO_IDX;
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_FINISH;
                    end
                end else begin
                    state_s = ST_RSTCMD;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
        // valid always drops for one cycle after a transfer, even when the
        // reset command directly follows the last colour
        valid_s = is_cmd_state(state_s) && !xfer_s;
    end

    // State and registered command/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            index_r   <= ZERO_IDX;
            valid_r   <= 1'b0;
            rst_cmd_r <= CMD_COLOR;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            index_r   <= index_s;
            valid_r   <= valid_s;
            rst_cmd_r <= (state_s == ST_RSTCMD) ? CMD_RESET : CMD_COLOR;
            busy_r    <= (state_s == ST_LOAD) || (state_s == ST_PRESENT) ||
                         (state_s == ST_RSTCMD);
            done_r    <= (state_s == ST_FINISH);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pix_valid = valid_r;
    assign pix_reset = rst_cmd_r;
    // RAM output is held between reads, so it is stable for the whole PRESENT
    assign pix_color = (valid_r && !rst_cmd_r) ? rd_data_s : {COLOR_W{1'b0}};

endmodule
